// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, issues one outstanding imem request,
// and holds the IF/ID pipeline register plus a one-entry skid for decode stalls.
//
// state  | meaning
// S_REQ  | request pc on imem, waiting for grant
// S_WAIT | request granted, waiting for response
// S_FULL | IF/ID full and response parked in skid, waiting for decode
// S_DROP | redirected while a request was in flight; discard its response
module if_stage #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [31:0]  id_instr,
  output logic [N-1:0] id_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pc, req_pc;
  logic [N-1:0] br_pc;
  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [N-1:0] skid_pc;
  logic         rsp_load_id, rsp_load_skid, skid_to_id, consume;

  assign br_pc   = br_target & ~{{(N-2){1'b0}}, 2'b11};
  assign consume = id_valid && id_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (br_taken) begin
      // a request still in flight past this edge must have its response absorbed
      if (((state == S_WAIT || state == S_DROP) && !imem_rvalid) ||
          (state == S_REQ && imem_gnt))
        state_nxt = S_DROP;
      else
        state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ:  if (imem_gnt) state_nxt = S_WAIT;
        S_WAIT: if (imem_rvalid) state_nxt = (!id_valid || id_ready) ? S_REQ : S_FULL;
        S_FULL: if (id_ready) state_nxt = S_REQ;
        S_DROP: if (imem_rvalid) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req      = (state == S_REQ) && reset;
    imem_addr     = pc;
    rsp_load_id   = !br_taken && (state == S_WAIT) && imem_rvalid && (!id_valid || id_ready);
    rsp_load_skid = !br_taken && (state == S_WAIT) && imem_rvalid && id_valid && !id_ready;
    skid_to_id    = !br_taken && (state == S_FULL) && id_ready && skid_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (state == S_REQ && imem_gnt)
        req_pc <= pc;

      if (br_taken)
        pc <= br_pc;
      else if (state == S_WAIT && imem_rvalid)
        pc <= req_pc + N'(4);

      if (br_taken) begin
        id_valid <= 1'b0;
      end else if (rsp_load_id) begin
        id_valid <= 1'b1;
        id_instr <= imem_rdata;
        id_pc    <= req_pc;
      end else if (skid_to_id) begin
        id_valid <= 1'b1;
        id_instr <= skid_instr;
        id_pc    <= skid_pc;
      end else if (consume) begin
        id_valid <= 1'b0;
      end

      if (br_taken || skid_to_id) begin
        skid_valid <= 1'b0;
      end else if (rsp_load_skid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset/first fetch, skid stall, the three redirect
// cases, and PC wrap on a second instance reset near the top of the address space.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_gnt, imem_rvalid, br_taken, id_ready;
  logic [31:0] imem_rdata;
  logic [63:0] br_target;

  logic        imem_req, id_valid;
  logic [63:0] imem_addr, id_pc;
  logic [31:0] id_instr;

  logic        w_imem_req, w_id_valid;
  logic [63:0] w_imem_addr, w_id_pc;
  logic [31:0] w_id_instr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_stage #(.N(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  if_stage #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .id_valid(w_id_valid), .id_ready(id_ready), .id_instr(w_id_instr), .id_pc(w_id_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    br_taken = 1'b0; br_target = '0; id_ready = 1'b1;
    repeat (3) tick();
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_w_req", {63'd0, w_imem_req}, 64'd0);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_id_instr", {32'd0, id_instr}, 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);

    // reset and first fetch
    reset = 1'b1;
    #1;
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'd0);
    chk("wrap_first_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hF84003E1;
    tick();
    imem_rvalid = 1'b0;
    chk("f1_valid", {63'd0, id_valid}, 64'd1);
    chk("f1_instr", {32'd0, id_instr}, 64'h0000_0000_F840_03E1);
    chk("f1_pc", id_pc, 64'd0);
    chk("f2_req", {63'd0, imem_req}, 64'd1);
    chk("f2_addr", imem_addr, 64'd4);
    chk("wrap_id_pc", w_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_id_instr", {32'd0, w_id_instr}, 64'h0000_0000_F840_03E1);
    chk("wrap_second_addr", w_imem_addr, 64'd0);
    chk("wrap_second_req", {63'd0, w_imem_req}, 64'd1);

    // async reset mid-run, then stall with skid
    tick();
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, id_valid}, 64'd0);
    chk("async_rst_req", {63'd0, imem_req}, 64'd0);
    tick();
    reset = 1'b1; id_ready = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000;
    tick();
    imem_rvalid = 1'b0;
    chk("d0_valid", {63'd0, id_valid}, 64'd1);
    chk("d1_addr", imem_addr, 64'd4);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0004;
    tick();
    imem_rvalid = 1'b0;
    chk("stall_instr", {32'd0, id_instr}, 64'h0000_0000_AAAA_0000);
    chk("stall_pc", id_pc, 64'd0);
    chk("stall_valid", {63'd0, id_valid}, 64'd1);
    chk("stall_no_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("stall_no_req2", {63'd0, imem_req}, 64'd0);
    chk("stall_hold_instr", {32'd0, id_instr}, 64'h0000_0000_AAAA_0000);
    id_ready = 1'b1;
    tick();
    chk("skid_instr", {32'd0, id_instr}, 64'h0000_0000_BBBB_0004);
    chk("skid_pc", id_pc, 64'd4);
    chk("skid_valid", {63'd0, id_valid}, 64'd1);
    chk("after_skid_req", {63'd0, imem_req}, 64'd1);
    chk("after_skid_addr", imem_addr, 64'd8);

    // redirect while waiting
    id_ready = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("pre_br_valid", {63'd0, id_valid}, 64'd1);
    br_taken = 1'b1; br_target = 64'h103;
    tick();
    br_taken = 1'b0;
    chk("br_wait_valid", {63'd0, id_valid}, 64'd0);
    chk("br_wait_noreq", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("drop_valid", {63'd0, id_valid}, 64'd0);
    chk("drop_instr_kept", {32'd0, id_instr}, 64'h0000_0000_BBBB_0004);
    chk("br_req", {63'd0, imem_req}, 64'd1);
    chk("br_addr", imem_addr, 64'h100);
    imem_gnt = 1'b1; id_ready = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8B02_0020;
    tick();
    imem_rvalid = 1'b0;
    chk("br_tgt_valid", {63'd0, id_valid}, 64'd1);
    chk("br_tgt_instr", {32'd0, id_instr}, 64'h0000_0000_8B02_0020);
    chk("br_tgt_pc", id_pc, 64'h100);
    chk("br_next_addr", imem_addr, 64'h104);

    // redirect coincident with rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    br_taken = 1'b1; br_target = 64'h200;
    tick();
    imem_rvalid = 1'b0; br_taken = 1'b0;
    chk("brrv_valid", {63'd0, id_valid}, 64'd0);
    chk("brrv_instr_kept", {32'd0, id_instr}, 64'h0000_0000_8B02_0020);
    chk("brrv_req", {63'd0, imem_req}, 64'd1);
    chk("brrv_addr", imem_addr, 64'h200);

    // redirect coincident with grant
    imem_gnt = 1'b1; br_taken = 1'b1; br_target = 64'h302;
    tick();
    imem_gnt = 1'b0; br_taken = 1'b0;
    chk("brg_noreq", {63'd0, imem_req}, 64'd0);
    tick();
    chk("brg_noreq2", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    chk("brg_drop_valid", {63'd0, id_valid}, 64'd0);
    chk("brg_req", {63'd0, imem_req}, 64'd1);
    chk("brg_addr", imem_addr, 64'h300);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    chk("brg_tgt_valid", {63'd0, id_valid}, 64'd1);
    chk("brg_tgt_instr", {32'd0, id_instr}, 64'h0000_0000_CAFE_F00D);
    chk("brg_tgt_pc", id_pc, 64'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with an integrated IF/ID pipeline register for the LEGv8 datapath. It owns the program counter and issues one-at-a-time requests to instruction memory. It presents each fetched 32-bit instruction and its PC to the decode stage, where the instruction feeds the sign extender and register file. It supports decode back-pressure (stall) and branch redirect (flush).

## Interface
- N, 64: PC and address width.
- RESET_PC, 64'h0: PC value after reset.
---
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_req  out  1  fetch request valid.
- imem_addr  out  N  fetch address; equals PC while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after grant.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- br_taken  in  1  redirect request from a later stage.
- br_target  in  N  redirect PC; bits [1:0] are ignored and forced to 0.
- id_valid  out  1  IF/ID register holds an instruction.
- id_ready  in  1  decode can consume; a transfer occurs when id_valid&&id_ready at the edge.
- id_instr  out  32  instruction to decode (sign-extender input).
- id_pc  out  N  PC of id_instr.

## Operation
- **State:**
  - pc register.
  - FSM {S_REQ, S_WAIT, S_FULL, S_DROP}.
  - IF/ID register {valid, instr, pc}.
  - One skid entry {instr, pc}.
  - req_pc, which holds the address of the outstanding request.
- **Reset values:** pc=RESET_PC, FSM=S_REQ, id_valid=0, id_instr=0, id_pc=0, skid empty. imem_req=0 while reset is asserted.
- **S_REQ:** imem_req=1, imem_addr=pc. On imem_gnt: req_pc<=pc, go to S_WAIT.
- **S_WAIT:** imem_req=0. On imem_rvalid:
  - If the IF/ID register is empty or being consumed this cycle: load {1, rdata, req_pc}, pc<=req_pc+4, go to S_REQ.
  - Otherwise: write the skid entry, pc<=req_pc+4, go to S_FULL.
- **S_FULL:** imem_req=0. When id_ready: skid moves into the IF/ID register, skid empties, go to S_REQ.
- **S_DROP:** imem_req=0. The next imem_rvalid is discarded, then go to S_REQ.
- **Consume:** if id_valid&&id_ready and nothing new loads, id_valid<=0. id_instr and id_pc keep their last values.
- **Redirect (br_taken=1):** has priority over every other event in the same cycle.
  - pc<={br_target[N-1:2],2'b00}; id_valid<=0; skid cleared.
  - Next state is S_DROP if a request is outstanding past this edge: either in S_WAIT with no rvalid this cycle, or in S_REQ with imem_gnt this cycle.
  - Next state is S_REQ otherwise, including when S_WAIT sees rvalid in the same cycle; that data is discarded.
- **PC arithmetic:** +4 modulo 2^N; wrap from 2^N-4 to 0 is silent.
- At most one outstanding memory request. The IF/ID register plus skid never hold more than 2 instructions.

## Timing
- Reset asserts asynchronously; outputs take their reset values immediately. The first imem_req is in the first cycle after reset deasserts.
- imem_req and imem_addr are combinational from state and pc only. There are no combinational paths from imem_gnt, imem_rvalid or id_ready to imem_req.
- id_valid, id_instr and id_pc are registered. An instruction appears on the edge that samples imem_rvalid.
- Best case (gnt in the request cycle, rvalid one cycle later): one instruction per 2 cycles.
- Redirect: a request to br_target is issued in the next cycle (S_REQ), or after the stale response is absorbed (S_DROP).
- Reset asserted mid-transaction abandons the outstanding request. Any late rvalid in S_REQ is ignored.
- imem_rvalid outside S_WAIT/S_DROP is ignored.

## Test plan
- **Reset and first fetch:** hold reset=0 for 3 cycles, release; gnt same cycle, rvalid next with 32'hF84003E1.
  - imem_req=1 with addr 0 in the first post-reset cycle.
  - id_valid=1, id_instr=F84003E1, id_pc=0.
  - Next request at addr 4.
- **Stall with skid:** id_ready=0 while two responses return (D0 at PC 0, D1 at PC 4).
  - id_instr holds D0 and D1 goes to the skid; no third imem_req.
  - Raise id_ready: D1/PC 4 appears, then a request to addr 8.
- **Redirect while waiting:** br_taken=1 with br_target=0x103 while in S_WAIT.
  - id_valid drops.
  - The next rvalid (0xDEADBEEF) is discarded.
  - Then imem_req with addr 0x100; the resulting id_pc is 0x100.
- **Redirect coincident with rvalid:** the data is never presented on id_instr, and a request to the target issues the next cycle.
- **Redirect coincident with grant in S_REQ:** exactly one response is dropped, then the target is fetched.
- **PC wrap, N=64, RESET_PC=64'hFFFF_FFFF_FFFF_FFFC:** the first fetch is at that address, the second at 0.
